// File: rtl/umi_rr_arbiter_if.sv
// UMI arbiter bus bundle: N packed requester lanes in, one shared registered lane out.
// The master modport is the requester/downstream side; the slave modport is the arbiter.
interface umi_rr_arbiter_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 256,
  parameter int unsigned CW = 32,
  parameter int unsigned AW = 64
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    umi_in_valid;
  logic [N*CW-1:0] umi_in_cmd;
  logic [N*AW-1:0] umi_in_dstaddr;
  logic [N*AW-1:0] umi_in_srcaddr;
  logic [N*DW-1:0] umi_in_data;
  logic [N-1:0]    umi_in_ready;

  logic            umi_out_valid;
  logic [CW-1:0]   umi_out_cmd;
  logic [AW-1:0]   umi_out_dstaddr;
  logic [AW-1:0]   umi_out_srcaddr;
  logic [DW-1:0]   umi_out_data;
  logic            umi_out_ready;
  logic [IW-1:0]   grant_id;

  modport master (
    output umi_in_valid, umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data,
    output umi_out_ready,
    input  umi_in_ready,
    input  umi_out_valid, umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data,
    input  grant_id
  );

  modport slave (
    input  umi_in_valid, umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data,
    input  umi_out_ready,
    output umi_in_ready,
    output umi_out_valid, umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data,
    output grant_id
  );
endinterface

// File: rtl/umi_rr_arbiter.sv
// Round-robin UMI arbiter: N requesters share one registered output; a multi-beat
// transaction (EOM=0 beats) locks the grant to its owner until the EOM beat.
module umi_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 256,
  parameter int unsigned CW = 32,
  parameter int unsigned AW = 64
) (
  input  logic             clk,
  input  logic             nreset,
  umi_rr_arbiter_if.slave  bus
);
  localparam int unsigned IW      = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned EOM_BIT = 22;

  typedef enum logic {ARB, LOCK} state_e;

  state_e        state_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] lock_id_q;
  logic [IW-1:0] grant_id_q;
  logic          out_valid_q;
  logic [CW-1:0] out_cmd_q;
  logic [AW-1:0] out_dstaddr_q;
  logic [AW-1:0] out_srcaddr_q;
  logic [DW-1:0] out_data_q;

  logic          load_en_c;
  logic [N-1:0]  grant_c;
  logic [IW-1:0] grant_idx_c;
  logic          accept_c;
  logic          eom_c;
  logic [IW-1:0] ptr_inc_c;
  logic [CW-1:0] sel_cmd_c;
  logic [AW-1:0] sel_dstaddr_c;
  logic [AW-1:0] sel_srcaddr_c;
  logic [DW-1:0] sel_data_c;

  assign load_en_c = !out_valid_q | bus.umi_out_ready;

  // Grant: locked owner in LOCK, else first valid requester searching upward from ptr.
  always_comb begin
    int unsigned   idx;
    logic [IW-1:0] sel;
    logic          found;
    grant_c     = '0;
    grant_idx_c = '0;
    idx         = 0;
    sel         = '0;
    found       = 1'b0;
    if (state_q == LOCK) begin
      grant_c[lock_id_q] = 1'b1;
      grant_idx_c        = lock_id_q;
    end else begin
      for (int i = 0; i < N; i++) begin
        idx = 32'(ptr_q) + 32'(i);
        if (idx >= N) idx = idx - N;
        sel = IW'(idx);
        if (!found && bus.umi_in_valid[sel]) begin
          grant_c[sel] = 1'b1;
          grant_idx_c  = sel;
          found        = 1'b1;
        end
      end
    end
  end

  assign accept_c = load_en_c & (|(grant_c & bus.umi_in_valid));

  // One-hot payload select of the granted lane.
  always_comb begin
    sel_cmd_c     = '0;
    sel_dstaddr_c = '0;
    sel_srcaddr_c = '0;
    sel_data_c    = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_c[k]) begin
        sel_cmd_c     = bus.umi_in_cmd[k*CW +: CW];
        sel_dstaddr_c = bus.umi_in_dstaddr[k*AW +: AW];
        sel_srcaddr_c = bus.umi_in_srcaddr[k*AW +: AW];
        sel_data_c    = bus.umi_in_data[k*DW +: DW];
      end
    end
  end

  assign eom_c     = sel_cmd_c[EOM_BIT];
  assign ptr_inc_c = (grant_idx_c == IW'(N - 1)) ? '0 : grant_idx_c + IW'(1);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= ARB;
      ptr_q         <= '0;
      lock_id_q     <= '0;
      grant_id_q    <= '0;
      out_valid_q   <= 1'b0;
      out_cmd_q     <= '0;
      out_dstaddr_q <= '0;
      out_srcaddr_q <= '0;
      out_data_q    <= '0;
    end else if (accept_c) begin
      out_valid_q   <= 1'b1;
      out_cmd_q     <= sel_cmd_c;
      out_dstaddr_q <= sel_dstaddr_c;
      out_srcaddr_q <= sel_srcaddr_c;
      out_data_q    <= sel_data_c;
      grant_id_q    <= grant_idx_c;
      if (eom_c) begin
        state_q <= ARB;
        ptr_q   <= ptr_inc_c;
      end else begin
        state_q   <= LOCK;
        lock_id_q <= grant_idx_c;
      end
    end else if (load_en_c) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.umi_in_ready    = {N{load_en_c}} & grant_c;
  assign bus.umi_out_valid   = out_valid_q;
  assign bus.umi_out_cmd     = out_cmd_q;
  assign bus.umi_out_dstaddr = out_dstaddr_q;
  assign bus.umi_out_srcaddr = out_srcaddr_q;
  assign bus.umi_out_data    = out_data_q;
  assign bus.grant_id        = grant_id_q;

endmodule

// File: tb/tb_umi_rr_arbiter.sv
// Bench for umi_rr_arbiter: per-requester source queues, a transaction-level
// arbitration model and an output scoreboard queue, directed then randomized.
module tb_umi_rr_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 256;
  localparam int unsigned CW = 32;
  localparam int unsigned AW = 64;
  localparam int unsigned IW = 2;

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct packed {
    logic [IW-1:0] id;
    beat_t         b;
  } exp_t;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  umi_rr_arbiter_if #(.N(N), .DW(DW), .CW(CW), .AW(AW)) bus ();

  umi_rr_arbiter #(.N(N), .DW(DW), .CW(CW), .AW(AW)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  beat_t src_q[N][$];
  exp_t  sb[$];
  int    hist[$];
  int    passed = 0;
  int    total  = 0;
  int    fails  = 0;
  int    wait_cnt[N];
  int    obs_out = 0;
  bit    gate[N];
  bit    out_rdy;
  logic [N-1:0] vld;
  int    m_ptr;
  bit    m_lock;
  int    m_lock_id;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk_beat(input logic eom);
    beat_t b;
    b.cmd      = $urandom;
    b.cmd[22]  = eom;
    b.dst      = {$urandom, $urandom};
    b.src      = {$urandom, $urandom};
    for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic bit busy();
    bit r = (sb.size() != 0);
    for (int k = 0; k < N; k++) if (src_q[k].size() != 0) r = 1'b1;
    return r;
  endfunction

  function automatic int model_grant();
    if (m_lock) return m_lock_id;
    for (int i = 0; i < N; i++) begin
      int idx = (m_ptr + i) % N;
      if (vld[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock: drive at negedge, predict, then check registered outputs after the edge.
  task automatic cycle();
    beat_t       b;
    exp_t        e;
    int          g;
    bit          load_en, accept;
    logic [N-1:0] exp_rdy;
    for (int k = 0; k < N; k++) begin
      vld[k] = gate[k] && (src_q[k].size() != 0);
      b      = vld[k] ? src_q[k][0] : '0;
      bus.umi_in_cmd[k*CW +: CW]     = b.cmd;
      bus.umi_in_dstaddr[k*AW +: AW] = b.dst;
      bus.umi_in_srcaddr[k*AW +: AW] = b.src;
      bus.umi_in_data[k*DW +: DW]    = b.data;
    end
    bus.umi_in_valid  = vld;
    bus.umi_out_ready = out_rdy;
    #1;
    load_en = (sb.size() == 0) || out_rdy;
    g       = model_grant();
    exp_rdy = '0;
    if (load_en && g >= 0) exp_rdy[g] = 1'b1;
    check("in_ready", DW'(bus.umi_in_ready), DW'(exp_rdy));
    if (bus.umi_out_valid && out_rdy) obs_out++;
    accept = load_en && (g >= 0) && vld[g];
    if (sb.size() != 0 && out_rdy) void'(sb.pop_front());
    for (int k = 0; k < N; k++) if (!vld[k]) wait_cnt[k] = 0;
    if (accept) begin
      b = src_q[g].pop_front();
      e.id = IW'(g);
      e.b  = b;
      sb.push_back(e);
      check("starve", DW'(wait_cnt[g] <= N - 1), DW'(1));
      wait_cnt[g] = 0;
      if (b.cmd[22]) begin
        m_lock = 1'b0;
        m_ptr  = (g + 1) % N;
        for (int k = 0; k < N; k++) if (k != g && vld[k]) wait_cnt[k]++;
      end else begin
        m_lock    = 1'b1;
        m_lock_id = g;
      end
    end
    @(posedge clk);
    #1;
    if (accept) hist.push_back(int'(bus.grant_id));
    if (sb.size() != 0) begin
      e = sb[0];
      check("out_valid", DW'(bus.umi_out_valid), DW'(1));
      check("grant_id", DW'(bus.grant_id), DW'(e.id));
      check("out_cmd", DW'(bus.umi_out_cmd), DW'(e.b.cmd));
      check("out_dst", DW'(bus.umi_out_dstaddr), DW'(e.b.dst));
      check("out_src", DW'(bus.umi_out_srcaddr), DW'(e.b.src));
      check("out_data", bus.umi_out_data, e.b.data);
    end else begin
      check("out_idle", DW'(bus.umi_out_valid), DW'(0));
    end
    @(negedge clk);
  endtask

  // Asserted away from any edge so the output must clear asynchronously.
  task automatic apply_reset();
    nreset = 1'b0;
    bus.umi_in_valid = '0;
    for (int k = 0; k < N; k++) begin
      src_q[k].delete();
      wait_cnt[k] = 0;
      gate[k]     = 1'b1;
    end
    sb.delete();
    hist.delete();
    m_ptr = 0; m_lock = 1'b0; m_lock_id = 0;
    #1;
    check("rst_valid", DW'(bus.umi_out_valid), DW'(0));
    check("rst_grant_id", DW'(bus.grant_id), DW'(0));
    check("rst_cmd", DW'(bus.umi_out_cmd), DW'(0));
    check("rst_data", bus.umi_out_data, '0);
    check("rst_ready", DW'(bus.umi_in_ready), DW'(0));
    @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic run_idle(input string tag);
    int n = 0;
    out_rdy = 1'b1;
    while (busy() && n < 500) begin
      cycle();
      n++;
    end
    check({tag, "_idle"}, DW'(busy()), DW'(0));
  endtask

  task automatic check_hist(input string tag, input int e[$]);
    check({tag, "_len"}, DW'(hist.size()), DW'(e.size()));
    for (int i = 0; i < e.size() && i < hist.size(); i++) check(tag, DW'(hist[i]), DW'(e[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    int    eq[$];
    int    gen_cnt;
    int    cyc;
    int    len;

    nreset = 1'b0;
    out_rdy = 1'b1;
    vld = '0;
    bus.umi_in_valid = '0;
    bus.umi_in_cmd = '0;
    bus.umi_in_dstaddr = '0;
    bus.umi_in_srcaddr = '0;
    bus.umi_in_data = '0;
    bus.umi_out_ready = 1'b1;
    @(negedge clk);
    apply_reset();

    // Lone requester 1 with a fixed payload, then ptr must have moved to 2.
    b = mk_beat(1'b1);
    b.cmd = 32'h0040_0003;
    b.dst = 64'h1234;
    src_q[1].push_back(b);
    cycle();
    check("d034_cmd", DW'(bus.umi_out_cmd), DW'(32'h0040_0003));
    check("d034_dst", DW'(bus.umi_out_dstaddr), DW'(64'h1234));
    check("d034_gid", DW'(bus.grant_id), DW'(1));
    for (int k = 0; k < 3; k++) src_q[k].push_back(mk_beat(1'b1));
    run_idle("d034");
    eq = '{1, 2, 0, 1};
    check_hist("d034_seq", eq);

    // All four busy with single-beat transactions: strict rotation, no gaps.
    apply_reset();
    for (int k = 0; k < N; k++) for (int t = 0; t < 2; t++) src_q[k].push_back(mk_beat(1'b1));
    for (int c = 0; c < 8; c++) begin
      cycle();
      check("d031_nogap", DW'(bus.umi_out_valid), DW'(1));
    end
    eq = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_hist("d031_seq", eq);
    run_idle("d031");

    // Backpressure with a beat loaded: everything holds, then drain and reload together.
    apply_reset();
    src_q[0].push_back(mk_beat(1'b1));
    src_q[1].push_back(mk_beat(1'b1));
    cycle();
    out_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("d033_ready", DW'(bus.umi_in_ready), DW'(0));
      check("d033_gid", DW'(bus.grant_id), DW'(0));
    end
    out_rdy = 1'b1;
    cycle();
    check("d033_reload_v", DW'(bus.umi_out_valid), DW'(1));
    check("d033_reload_g", DW'(bus.grant_id), DW'(1));
    run_idle("d033");

    // Three-beat transaction on 2 holds the grant against 0, 1 and 3.
    apply_reset();
    src_q[1].push_back(mk_beat(1'b1));
    cycle();
    src_q[2].push_back(mk_beat(1'b0));
    src_q[2].push_back(mk_beat(1'b0));
    src_q[2].push_back(mk_beat(1'b1));
    src_q[0].push_back(mk_beat(1'b1));
    src_q[1].push_back(mk_beat(1'b1));
    src_q[3].push_back(mk_beat(1'b1));
    run_idle("d032");
    eq = '{1, 2, 2, 2, 3, 0, 1};
    check_hist("d032_seq", eq);

    // Reset while locked on 3 drops the beat and the lock.
    apply_reset();
    src_q[3].push_back(mk_beat(1'b0));
    src_q[3].push_back(mk_beat(1'b1));
    cycle();
    check("d035_locked_v", DW'(bus.umi_out_valid), DW'(1));
    apply_reset();
    src_q[3].push_back(mk_beat(1'b1));
    src_q[0].push_back(mk_beat(1'b1));
    run_idle("d035");
    eq = '{0, 3};
    check_hist("d035_seq", eq);

    // Randomized valid gating and downstream ready with multi-beat transactions.
    apply_reset();
    gen_cnt = 0;
    for (int k = 0; k < N; k++) begin
      for (int t = 0; t < 8; t++) begin
        len = $urandom_range(1, 3);
        for (int i = 0; i < len; i++) begin
          src_q[k].push_back(mk_beat(i == len - 1));
          gen_cnt++;
        end
      end
    end
    obs_out = 0;
    cyc = 0;
    while (busy() && cyc < 4000) begin
      for (int k = 0; k < N; k++) gate[k] = ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 9) < 7);
      cycle();
      cyc++;
    end
    check("rand_drain", DW'(busy()), DW'(0));
    out_rdy = 1'b1;
    cycle();
    check("rand_count", DW'(obs_out), DW'(gen_cnt));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/umi_rr_arbiter.md
UMI_RR_ARBITER -- requirements
Module: umi_rr_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of UMI input requesters.
REQ-002 The block SHALL have parameter DW, default 256, giving the UMI data width.
REQ-003 The block SHALL have parameter CW, default 32, giving the UMI command width.
REQ-004 The block SHALL have parameter AW, default 64, giving the UMI address width.
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 nreset  input  1  asynchronous, active-low reset.
REQ-007 umi_in_valid  input  N  per-requester valid.
REQ-008 umi_in_cmd  input  N*CW  per-requester command; requester k occupies bits [k*CW +: CW].
REQ-009 umi_in_dstaddr / umi_in_srcaddr  input  N*AW each  per-requester addresses, same packing as REQ-008.
REQ-010 umi_in_data  input  N*DW  per-requester data, same packing as REQ-008.
REQ-011 umi_in_ready  output  N  per-requester ready.
REQ-012 umi_out_valid, umi_out_cmd[CW], umi_out_dstaddr[AW], umi_out_srcaddr[AW], umi_out_data[DW]  outputs  shared registered UMI output.
REQ-013 umi_out_ready  input  1  downstream ready.
REQ-014 grant_id  output  clog2(N)  index of the requester whose transaction currently sits in the output register.

Function
REQ-015 Transfer rule: an input beat transfers on a cycle when valid and ready are both high; the output transfers when umi_out_valid and umi_out_ready are both high.
REQ-016 load_en SHALL equal (!umi_out_valid | umi_out_ready), giving full throughput of one beat per cycle.
REQ-017 At most one umi_in_ready bit SHALL be high in any cycle: umi_in_ready[k] = load_en & grant[k].
REQ-018 grant SHALL be one-hot or zero, and SHALL be computed combinationally from umi_in_valid, the pointer ptr, and the state.
REQ-019 In state ARB, grant SHALL select the first valid requester found by searching ptr, ptr+1, ... modulo N; grant SHALL be zero when no input is valid.
REQ-020 In state LOCK, grant SHALL be fixed to lock_id regardless of other valids, and a deasserted valid on lock_id SHALL stall without re-arbitration.
REQ-021 On an accepted input beat from requester k, the output register SHALL load that requester's cmd, dstaddr, srcaddr and data, set umi_out_valid=1 and set grant_id=k; output latency SHALL be 1 cycle.
REQ-022 When load_en=1 and no beat is accepted, umi_out_valid SHALL clear; when load_en=0, the output register SHALL hold all values.
REQ-023 EOM SHALL be cmd bit 22.
REQ-024 Accepted beat with EOM=0: state SHALL go to LOCK with lock_id=k, and ptr SHALL be unchanged.
REQ-025 Accepted beat with EOM=1, in either state: state SHALL go to ARB and ptr SHALL become (k+1) mod N, wrapping N-1 to 0.
REQ-026 Output payload SHALL pass through bit-exact, with no modification of cmd or addresses.
REQ-027 Changes of umi_in_valid on non-granted inputs SHALL NOT affect the output register or ptr.

Reset
REQ-028 While nreset=0: umi_out_valid=0, umi_out_cmd/dstaddr/srcaddr/data=0, grant_id=0, ptr=0, state=ARB, lock_id=0.
REQ-029 Reset assertion mid-transaction, including in LOCK, SHALL asynchronously discard the output register beat and the lock; no partial state SHALL survive.
REQ-030 After reset deassertion, the first arbitration SHALL start from requester 0.

Verification
REQ-031 All 4 inputs hold valid with EOM=1 and umi_out_ready=1 -> output grant_id sequence 0,1,2,3,0,... with one beat per cycle and no gaps.
REQ-032 Input 2 sends a 3-beat transaction (EOM=0,0,1) while inputs 0, 1 and 3 are valid -> three consecutive beats from 2, then input 3 is granted, then 0.
REQ-033 umi_out_ready held 0 for 5 cycles with one beat loaded -> output is stable, all umi_in_ready=0, ptr is unchanged; on release the beat drains and the next beat loads in the same cycle.
REQ-034 Only input 1 is valid, cmd=32'h0040_0003, dstaddr=64'h1234 -> one cycle later umi_out_cmd=32'h0040_0003, umi_out_dstaddr=64'h1234, grant_id=1, and the next ptr=2.
REQ-035 nreset pulsed low while in LOCK on input 3 -> umi_out_valid=0 immediately; after release, input 0 wins over input 3 when both are valid.
REQ-036 Randomized valid/ready with scoreboards on every input -> no lost, duplicated or interleaved-within-transaction beats, and no requester starved beyond N transactions.
